scsi_sm: RTL and testbench
==========================

# scsi_sm

Cycle-level controller between the CPU bus, the DMA FIFO and the WD33C93 SCSI chip in the SDMAC replacement. It arbitrates CPU register accesses against byte-wide DMA transfers. It generates the SCSI chip strobes: chip select, RE, WE and DACK. It also generates the byte-steering and latch enables, plus the byte-pointer and FIFO-pointer increment pulses used by the surrounding FIFO logic.

## Interface
- No parameters.
- CPUCLK in 1: system clock; all state changes on the rising edge.
- RESET_ in 1: asynchronous, active-low reset.
- CPUREQ in 1: CPU access to the SCSI chip requested.
- nAS_ in 1: CPU address strobe, active-low.
- RW in 1: 1 = CPU read, 0 = CPU write.
- DMADIR in 1: 1 = SCSI→FIFO (DMA read), 0 = FIFO→SCSI (DMA write).
- DREQ_ in 1: SCSI DMA request, active-low.
- BOEQ3 in 1: external byte pointer equals 3.
- FIFOFULL in 1: FIFO full flag.
- FIFOEMPTY in 1: FIFO empty flag.
- INCFIFO in 1: FIFO count update pending (increment).
- DECFIFO in 1: FIFO count update pending (decrement).
- SCSI_CS_o out 1: SCSI chip select.
- RE_o out 1: SCSI read strobe.
- WE_o out 1: SCSI write strobe.
- DACK_o out 1: DMA acknowledge.
- S2F_o out 1: SCSI→FIFO data path enable.
- F2S_o out 1: FIFO→SCSI data path enable.
- S2CPU_o out 1: SCSI→CPU data path enable.
- CPU2S_o out 1: CPU→SCSI data path enable.
- LS2CPU out 1: latch SCSI data for the CPU.
- LBYTE_ out 1: latch DMA-read byte into the FIFO byte lane, active-low.
- INCBO_o out 1: increment byte pointer.
- INCNI_o out 1: increment FIFO next-in pointer.
- INCNO_o out 1: increment FIFO next-out pointer.
- RIFIFO_o out 1: write the assembled longword into the FIFO.
- RDFIFO_o out 1: load a FIFO longword into the output byte latch.

## Operation
- Moore FSM. Outputs decode from the state register only.
- Reset: state IDLE, all outputs 0 except LBYTE_=1; flags LAST=0, NEEDLOAD=1.
- IDLE arbitration, highest priority first:
  - CPUREQ=1 & nAS_=0 → C_SETUP; latch RW.
  - Else, if DREQ_=0 & INCFIFO=0 & DECFIFO=0:
    - DMADIR=1 & !FIFOFULL → D_ACK as a read; latch DMADIR.
    - DMADIR=0 & !FIFOEMPTY → D_ACK as a write; latch DMADIR.
  - Else stay in IDLE.
- CPU path: C_SETUP → C_STRB1 → C_STRB2 → C_END → C_WAIT.
  - SCSI_CS_o is high in C_SETUP through C_END.
  - S2CPU_o (read) or CPU2S_o (write) is high in the same states.
  - RE_o (read) or WE_o (write) is high in C_STRB1/2.
  - LS2CPU is high in C_END, reads only.
  - C_WAIT holds until CPUREQ=0 or nAS_=1, then → IDLE.
- DMA path: D_ACK → D_STRB1 → D_STRB2 → D_LATCH → (LAST ? D_INCN : D_REC); D_INCN → D_REC; D_REC → IDLE.
  - DACK_o is high in D_ACK through D_LATCH.
  - S2F_o (read) or F2S_o (write) is high in the same states.
  - RE_o (read) or WE_o (write) is high in D_STRB1/2.
  - D_ACK captures LAST <= BOEQ3.
  - D_LATCH asserts INCBO_o. For reads it also asserts LBYTE_=0, and RIFIFO_o when LAST=1.
  - D_INCN asserts INCNI_o (read) or INCNO_o (write). A write also sets NEEDLOAD.
  - Write D_ACK with NEEDLOAD=1 asserts RDFIFO_o and clears NEEDLOAD.
- A DMA byte already started always completes, even if DREQ_ deasserts or CPUREQ arrives.
- RE_o and WE_o are never high together. SCSI_CS_o and DACK_o are never high together.

## Timing
- CPU access: 4 asserted cycles plus C_WAIT. SCSI_CS_o rises 1 cycle after IDLE samples the request.
- DMA byte: 6 cycles, or 7 cycles when LAST=1. DREQ_ is resampled in IDLE.
- INCBO_o, INCNI_o, INCNO_o, RIFIFO_o and RDFIFO_o are exactly 1-cycle pulses.
- BOEQ3 is sampled before INCBO_o fires, so the external pointer may change during D_LATCH.
- D_REC gives FIFOFULL and FIFOEMPTY one cycle to settle after INCNI_o or INCNO_o and the registered INCFIFO update.
- Asynchronous reset mid-cycle drops all strobes immediately and returns the FSM to IDLE.

## Configuration
- SCSI_SM_WAIT_STATE_EN defined: adds a third strobe state (C_STRB3, D_STRB3). RE_o/WE_o then last 3 cycles; CPU access has 5 asserted cycles and a DMA byte takes 7/8 cycles.
- Undefined: 2-cycle strobes as specified above.

## Structure
- scsi_sm_pkg holds:
  - the state enum: IDLE, C_SETUP, C_STRB1..3, C_END, C_WAIT, D_ACK, D_STRB1..3, D_LATCH, D_INCN, D_REC;
  - output-vector bit constants.
- Single module, no sub-module.

## Test plan
- Reset with DREQ_=1: all outputs 0, LBYTE_=1; no activity for 10 cycles.
- DMADIR=1, DREQ_=0, external byte/longword counters:
  - 4 INCBO_o pulses 6, 6, 6, 7 cycles apart, then one RIFIFO_o and one INCNI_o;
  - counter advances to 1 longword.
- DMA read continued: stops at FIFOFULL=1 (8 longwords). No DACK_o while full.
- DMADIR=0 with FIFOEMPTY=0: RDFIFO_o on the first byte, WE_o 2 cycles per byte, INCNO_o after the 4th byte.
- CPUREQ=1, nAS_=0, RW=1: SCSI_CS_o 4 cycles, RE_o 2 cycles, LS2CPU 1 cycle; IDLE after nAS_=1.
- CPUREQ raised mid DMA byte: byte completes, then the CPU cycle runs. Reset asserted in D_STRB1: outputs clear asynchronously.

Source files
------------

// File: rtl/scsi_sm_pkg.sv
// Shared types for the SCSI/DMA cycle controller: state encoding and output-vector bit positions.
// The C_STRB3/D_STRB3 states are only reachable when SCSI_SM_WAIT_STATE_EN is defined.
package scsi_sm_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        C_SETUP = 4'd1,
        C_STRB1 = 4'd2,
        C_STRB2 = 4'd3,
        C_STRB3 = 4'd4,
        C_END   = 4'd5,
        C_WAIT  = 4'd6,
        D_ACK   = 4'd7,
        D_STRB1 = 4'd8,
        D_STRB2 = 4'd9,
        D_STRB3 = 4'd10,
        D_LATCH = 4'd11,
        D_INCN  = 4'd12,
        D_REC   = 4'd13
    } state_t;

    localparam int OUT_W     = 15;
    localparam int O_RDFIFO  = 0;
    localparam int O_RIFIFO  = 1;
    localparam int O_INCNO   = 2;
    localparam int O_INCNI   = 3;
    localparam int O_INCBO   = 4;
    localparam int O_LBYTE_N = 5;
    localparam int O_LS2CPU  = 6;
    localparam int O_CPU2S   = 7;
    localparam int O_S2CPU   = 8;
    localparam int O_F2S     = 9;
    localparam int O_S2F     = 10;
    localparam int O_DACK    = 11;
    localparam int O_WE      = 12;
    localparam int O_RE      = 13;
    localparam int O_CS      = 14;

    // Quiescent output vector: everything low except the active-low byte latch enable.
    localparam logic [OUT_W-1:0] OUT_IDLE = 15'b000_0000_0010_0000;

    function automatic logic is_strobe_state(state_t s);
        return (s == C_STRB1) || (s == C_STRB2) || (s == C_STRB3) ||
               (s == D_STRB1) || (s == D_STRB2) || (s == D_STRB3);
    endfunction

    function automatic logic is_cpu_active(state_t s);
        return (s == C_SETUP) || (s == C_STRB1) || (s == C_STRB2) ||
               (s == C_STRB3) || (s == C_END);
    endfunction

    function automatic logic is_dma_active(state_t s);
        return (s == D_ACK) || (s == D_STRB1) || (s == D_STRB2) ||
               (s == D_STRB3) || (s == D_LATCH);
    endfunction

endpackage

// File: rtl/scsi_sm.sv
// Moore controller arbitrating CPU register cycles against byte-wide DMA to the WD33C93.
// Define SCSI_SM_WAIT_STATE_EN to stretch RE/WE strobes from 2 to 3 cycles.
module scsi_sm
    import scsi_sm_pkg::*;
(
    input  logic CPUCLK,
    input  logic RESET_,
    input  logic CPUREQ,
    input  logic nAS_,
    input  logic RW,
    input  logic DMADIR,
    input  logic DREQ_,
    input  logic BOEQ3,
    input  logic FIFOFULL,
    input  logic FIFOEMPTY,
    input  logic INCFIFO,
    input  logic DECFIFO,
    output logic SCSI_CS_o,
    output logic RE_o,
    output logic WE_o,
    output logic DACK_o,
    output logic S2F_o,
    output logic F2S_o,
    output logic S2CPU_o,
    output logic CPU2S_o,
    output logic LS2CPU,
    output logic LBYTE_,
    output logic INCBO_o,
    output logic INCNI_o,
    output logic INCNO_o,
    output logic RIFIFO_o,
    output logic RDFIFO_o
);

    state_t state_q, state_d;
    logic   rw_q, rw_d;
    logic   dir_q, dir_d;
    logic   last_q, last_d;
    logic   needload_q, needload_d;
    logic [OUT_W-1:0] out_vec;

    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            dir_q      <= 1'b0;
            last_q     <= 1'b0;
            needload_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            dir_q      <= dir_d;
            last_q     <= last_d;
            needload_q <= needload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        dir_d      = dir_q;
        last_d     = last_q;
        needload_d = needload_q;
        unique case (state_q)
            IDLE: begin
                // CPU wins; DMA waits for any pending FIFO count update to land.
                if (CPUREQ && !nAS_) begin
                    state_d = C_SETUP;
                    rw_d    = RW;
                end else if (!DREQ_ && !INCFIFO && !DECFIFO) begin
                    if (DMADIR && !FIFOFULL) begin
                        state_d = D_ACK;
                        dir_d   = 1'b1;
                    end else if (!DMADIR && !FIFOEMPTY) begin
                        state_d = D_ACK;
                        dir_d   = 1'b0;
                    end
                end
            end
            C_SETUP: state_d = C_STRB1;
            C_STRB1: state_d = C_STRB2;
`ifdef SCSI_SM_WAIT_STATE_EN
            C_STRB2: state_d = C_STRB3;
`else
            C_STRB2: state_d = C_END;
`endif
            C_STRB3: state_d = C_END;
            C_END:   state_d = C_WAIT;
            C_WAIT: begin
                if (!CPUREQ || nAS_) begin
                    state_d = IDLE;
                end
            end
            D_ACK: begin
                // Sample the byte pointer before INCBO can move it.
                state_d = D_STRB1;
                last_d  = BOEQ3;
                if (!dir_q) begin
                    needload_d = 1'b0;
                end
            end
            D_STRB1: state_d = D_STRB2;
`ifdef SCSI_SM_WAIT_STATE_EN
            D_STRB2: state_d = D_STRB3;
`else
            D_STRB2: state_d = D_LATCH;
`endif
            D_STRB3: state_d = D_LATCH;
            D_LATCH: state_d = last_q ? D_INCN : D_REC;
            D_INCN: begin
                state_d = D_REC;
                if (!dir_q) begin
                    needload_d = 1'b1;
                end
            end
            D_REC:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic cpu_act;
        logic dma_act;
        logic strb;
        logic rd_sel;
        out_vec = OUT_IDLE;
        cpu_act = is_cpu_active(state_q);
        dma_act = is_dma_active(state_q);
        strb    = is_strobe_state(state_q);
        rd_sel  = cpu_act ? rw_q : dir_q;

        out_vec[O_CS]      = cpu_act;
        out_vec[O_S2CPU]   = cpu_act && rw_q;
        out_vec[O_CPU2S]   = cpu_act && !rw_q;
        out_vec[O_LS2CPU]  = (state_q == C_END) && rw_q;
        out_vec[O_RE]      = strb && rd_sel;
        out_vec[O_WE]      = strb && !rd_sel;
        out_vec[O_DACK]    = dma_act;
        out_vec[O_S2F]     = dma_act && dir_q;
        out_vec[O_F2S]     = dma_act && !dir_q;
        out_vec[O_LBYTE_N] = !((state_q == D_LATCH) && dir_q);
        out_vec[O_INCBO]   = (state_q == D_LATCH);
        out_vec[O_RIFIFO]  = (state_q == D_LATCH) && dir_q && last_q;
        out_vec[O_INCNI]   = (state_q == D_INCN) && dir_q;
        out_vec[O_INCNO]   = (state_q == D_INCN) && !dir_q;
        out_vec[O_RDFIFO]  = (state_q == D_ACK) && !dir_q && needload_q;
    end

    assign SCSI_CS_o = out_vec[O_CS];
    assign RE_o      = out_vec[O_RE];
    assign WE_o      = out_vec[O_WE];
    assign DACK_o    = out_vec[O_DACK];
    assign S2F_o     = out_vec[O_S2F];
    assign F2S_o     = out_vec[O_F2S];
    assign S2CPU_o   = out_vec[O_S2CPU];
    assign CPU2S_o   = out_vec[O_CPU2S];
    assign LS2CPU    = out_vec[O_LS2CPU];
    assign LBYTE_    = out_vec[O_LBYTE_N];
    assign INCBO_o   = out_vec[O_INCBO];
    assign INCNI_o   = out_vec[O_INCNI];
    assign INCNO_o   = out_vec[O_INCNO];
    assign RIFIFO_o  = out_vec[O_RIFIFO];
    assign RDFIFO_o  = out_vec[O_RDFIFO];

endmodule

// File: tb/tb_scsi_sm.sv
// Directed + randomized bench for scsi_sm; expectations come from a transaction timeline and an external FIFO/byte-pointer model.
module tb_scsi_sm;

`ifdef SCSI_SM_WAIT_STATE_EN
    localparam int NS = 3;
`else
    localparam int NS = 2;
`endif
    localparam logic [14:0] IDLE_V = 15'h0020;

    logic CPUCLK = 1'b0;
    logic RESET_, CPUREQ, nAS_, RW, DMADIR, DREQ_, BOEQ3, FIFOFULL, FIFOEMPTY, INCFIFO, DECFIFO;
    logic SCSI_CS_o, RE_o, WE_o, DACK_o, S2F_o, F2S_o, S2CPU_o, CPU2S_o, LS2CPU, LBYTE_;
    logic INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o;

    scsi_sm dut (
        .CPUCLK(CPUCLK), .RESET_(RESET_), .CPUREQ(CPUREQ), .nAS_(nAS_), .RW(RW),
        .DMADIR(DMADIR), .DREQ_(DREQ_), .BOEQ3(BOEQ3), .FIFOFULL(FIFOFULL),
        .FIFOEMPTY(FIFOEMPTY), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
        .SCSI_CS_o(SCSI_CS_o), .RE_o(RE_o), .WE_o(WE_o), .DACK_o(DACK_o),
        .S2F_o(S2F_o), .F2S_o(F2S_o), .S2CPU_o(S2CPU_o), .CPU2S_o(CPU2S_o),
        .LS2CPU(LS2CPU), .LBYTE_(LBYTE_), .INCBO_o(INCBO_o), .INCNI_o(INCNI_o),
        .INCNO_o(INCNO_o), .RIFIFO_o(RIFIFO_o), .RDFIFO_o(RDFIFO_o)
    );

    always #5 CPUCLK = ~CPUCLK;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;
    int bo     = 0;   // external byte pointer 0..3
    int lw     = 0;   // longwords held in the FIFO, 0..8
    bit needload = 1'b1;
    int incbo_t[$];

    function automatic logic [14:0] obs();
        return {SCSI_CS_o, RE_o, WE_o, DACK_o, S2F_o, F2S_o, S2CPU_o, CPU2S_o,
                LS2CPU, LBYTE_, INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o};
    endfunction

    function automatic logic [14:0] vec(input bit cs, re, we, dack, s2f, f2s, s2c, c2s,
                                        ls, lbn, incbo, incni, incno, rif, rdf);
        return {cs, re, we, dack, s2f, f2s, s2c, c2s, ls, lbn, incbo, incni, incno, rif, rdf};
    endfunction

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
        total++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        total++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic drive_env();
        BOEQ3     = (bo == 3);
        FIFOFULL  = (lw >= 8);
        FIFOEMPTY = (lw == 0);
    endtask

    // One clock; the external pointer/FIFO logic reacts to the pulses seen during the cycle.
    task automatic tick();
        logic p_bo, p_ni, p_no;
        p_bo = INCBO_o; p_ni = INCNI_o; p_no = INCNO_o;
        if (p_bo) incbo_t.push_back(cyc);
        @(posedge CPUCLK); #1;
        cyc++;
        if (p_bo) bo = (bo + 1) % 4;
        if (p_ni) lw++;
        if (p_no && lw > 0) lw--;
        drive_env();
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, obs(), IDLE_V);
        end
    endtask

    // One DMA byte requested from IDLE; byte length is 1+NS+2 cycles (+1 for the last byte of a longword).
    task automatic dma_byte(input bit rd, input bit disturb, input bit cpu_mid);
        bit go, last;
        int len;
        string tg;
        tg = rd ? "dma_rd" : "dma_wr";
        if ($urandom_range(0, 1) != 0) begin CPUREQ = 1'b0; nAS_ = 1'($urandom_range(0, 1)); end
        else begin CPUREQ = 1'b1; nAS_ = 1'b1; end
        DREQ_ = 1'b0; DMADIR = rd; INCFIFO = 1'b0; DECFIFO = 1'b0;
        go   = rd ? (lw < 8) : (lw > 0);
        last = (bo == 3);
        if (!go) begin
            tick();
            chk("dma_blocked", obs(), IDLE_V);
            return;
        end
        len = 3 + NS + (last ? 1 : 0);
        for (int c = 1; c <= len; c++) begin
            bit dk, st, lt, inc, rdf;
            tick();
            dk  = (c <= 2 + NS);
            st  = (c >= 2) && (c <= 1 + NS);
            lt  = (c == 2 + NS);
            inc = last && (c == 3 + NS);
            rdf = !rd && needload && (c == 1);
            chk(tg, obs(), vec(1'b0, rd & st, !rd & st, dk, rd & dk, !rd & dk, 1'b0, 1'b0,
                               1'b0, !(rd & lt), lt, rd & inc, !rd & inc, rd & last & lt, rdf));
            if (rdf) needload = 1'b0;
            if (!rd && inc) needload = 1'b1;
            if (c == 1 && disturb) begin
                DREQ_  = 1'($urandom_range(0, 1));
                DMADIR = 1'($urandom_range(0, 1));
            end
            if (c == 2 && cpu_mid) begin
                CPUREQ = 1'b1; nAS_ = 1'b0; RW = 1'($urandom_range(0, 1));
            end
        end
        tick();
        chk("dma_rec_idle", obs(), IDLE_V);
    endtask

    task automatic cpu_cycle(input bit rd, input int w);
        string tg;
        tg = rd ? "cpu_rd" : "cpu_wr";
        CPUREQ = 1'b1; nAS_ = 1'b0; RW = rd;
        for (int c = 1; c <= 2 + NS; c++) begin
            bit st;
            tick();
            st = (c >= 2) && (c <= 1 + NS);
            chk(tg, obs(), vec(1'b1, rd & st, !rd & st, 1'b0, 1'b0, 1'b0, rd, !rd,
                               rd && (c == 2 + NS), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            if (c == 1) RW = 1'($urandom_range(0, 1));
        end
        idle_cycles(w + 1, "cpu_wait");
        if ($urandom_range(0, 1) != 0) CPUREQ = 1'b0;
        else nAS_ = 1'b1;
        tick();
        chk("cpu_end", obs(), IDLE_V);
    endtask

    task automatic blocked_gap();
        CPUREQ = 1'b0; nAS_ = 1'($urandom_range(0, 1));
        INCFIFO = 1'b0; DECFIFO = 1'b0; DMADIR = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: DREQ_ = 1'b1;
            1: begin DREQ_ = 1'b0; INCFIFO = 1'b1; end
            2: begin DREQ_ = 1'b0; DECFIFO = 1'b1; end
            default: begin DREQ_ = 1'b1; CPUREQ = 1'b1; nAS_ = 1'b1; end
        endcase
        tick();
        chk("blocked_gap", obs(), IDLE_V);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd;
        RESET_ = 1'b0; CPUREQ = 1'b0; nAS_ = 1'b1; RW = 1'b0; DMADIR = 1'b0; DREQ_ = 1'b1;
        INCFIFO = 1'b0; DECFIFO = 1'b0;
        drive_env();
        repeat (2) @(posedge CPUCLK);
        #1;
        chk("reset_outputs", obs(), IDLE_V);
        RESET_ = 1'b1;
        idle_cycles(10, "reset_idle");

        // DMA read of one longword, then one more byte to see the long gap after the last byte.
        incbo_t.delete();
        repeat (4) dma_byte(1'b1, 1'b0, 1'b0);
        chk_int("lw_after_4_reads", lw, 1);
        chk_int("bo_after_4_reads", bo, 0);
        dma_byte(1'b1, 1'b0, 1'b0);
        chk_int("incbo_count", incbo_t.size(), 5);
        if (incbo_t.size() == 5) begin
            chk_int("incbo_gap1", incbo_t[1] - incbo_t[0], 4 + NS);
            chk_int("incbo_gap2", incbo_t[2] - incbo_t[1], 4 + NS);
            chk_int("incbo_gap3", incbo_t[3] - incbo_t[2], 4 + NS);
            chk_int("incbo_gap4", incbo_t[4] - incbo_t[3], 5 + NS);
        end

        // Fill the FIFO; no DACK once it reports full.
        for (int k = 0; k < 40 && lw < 8; k++) dma_byte(1'b1, 1'b0, 1'b0);
        chk_int("lw_full", lw, 8);
        CPUREQ = 1'b0; DREQ_ = 1'b0; DMADIR = 1'b1;
        idle_cycles(6, "full_no_dack");

        // DMA write of one longword: RDFIFO on first byte, INCNO after the fourth.
        repeat (4) dma_byte(1'b0, 1'b0, 1'b0);
        chk_int("lw_after_4_writes", lw, 7);

        cpu_cycle(1'b1, 2);
        cpu_cycle(1'b0, 0);

        // CPU arrives mid byte; DREQ_ dropping mid byte must not abort it.
        dma_byte(1'b0, 1'b0, 1'b1);
        cpu_cycle(1'b1, 1);
        dma_byte(1'b1, 1'b1, 1'b0);
        blocked_gap();

        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) dma_byte(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            else if (r == 5) begin
                dma_byte(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                cpu_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end else if (r < 8) cpu_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 2));
            else blocked_gap();
        end

        // Asynchronous reset during D_STRB1.
        rd = (lw < 8);
        CPUREQ = 1'b0; nAS_ = 1'b1; DREQ_ = 1'b0; DMADIR = rd; INCFIFO = 1'b0; DECFIFO = 1'b0;
        tick();
        chk_int("rst_pre_dack", int'(DACK_o), 1);
        tick();
        chk_int("rst_pre_strobe", int'(rd ? RE_o : WE_o), 1);
        #2 RESET_ = 1'b0;
        #1 chk("async_reset", obs(), IDLE_V);
        @(posedge CPUCLK); #1;
        chk("reset_held", obs(), IDLE_V);
        RESET_ = 1'b1;
        bo = 0; needload = 1'b1; DREQ_ = 1'b1;
        drive_env();
        idle_cycles(3, "post_reset_idle");
        if (lw == 0) repeat (4) dma_byte(1'b1, 1'b0, 1'b0);
        dma_byte(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
